// File: rtl/mux_arbiter_if.sv
// Handshake/bus bundle between the two producers, the arbiter and the downstream consumer.
// The master modport is the producer/consumer side; the slave modport is the arbiter.
interface mux_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req_a;
    logic [WIDTH-1:0] data_a;
    logic             req_b;
    logic [WIDTH-1:0] data_b;
    logic             out_ready;
    logic             gnt_a;
    logic             gnt_b;
    logic             select;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;

    modport master (
        output req_a, data_a, req_b, data_b, out_ready,
        input  gnt_a, gnt_b, select, out_data, out_valid
    );

    modport slave (
        input  req_a, data_a, req_b, data_b, out_ready,
        output gnt_a, gnt_b, select, out_data, out_valid
    );
endinterface

// File: rtl/mux_arbiter.sv
// Round-robin arbiter/sequencer for the shared 2:1 mux datapath.
// Two requesters (A, B) share one output channel; each ownership is capped at BURST_LEN
// beats while the other side waits, and the hand-over happens with no idle bubble.
// The FSM state is encoded directly as {gnt_b, gnt_a}; select is a separate register
// so that it can hold its last value while idle.
// Optional build macro MUX_ARB_STATS_EN adds saturating per-requester beat counters
// cnt_a/cnt_b; arbitration behaviour is identical with or without it.
module mux_arbiter #(
    parameter int WIDTH     = 8,
    parameter int BURST_LEN = 4
) (
    input  logic               clk,
    input  logic               reset,
    mux_arbiter_if.slave       bus
`ifdef MUX_ARB_STATS_EN
    ,
    output logic [7:0]         cnt_a,
    output logic [7:0]         cnt_b
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_A = 2'b01,
        OWN_B = 2'b10
    } state_t;

    localparam int            CW       = $clog2(BURST_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BURST_LEN - 1);

    state_t           state_q;
    state_t           state_d;
    logic             select_q;
    logic             select_d;
    logic             last_b_q;
    logic             last_b_d;
    logic [CW-1:0]    beat_cnt_q;
    logic [CW-1:0]    beat_cnt_d;
    logic             beat;
    logic [WIDTH-1:0] mux_out;

    assign bus.gnt_a     = (state_q == OWN_A);
    assign bus.gnt_b     = (state_q == OWN_B);
    assign bus.select    = select_q;
    assign bus.out_valid = (bus.gnt_a & bus.req_a) | (bus.gnt_b & bus.req_b);
    assign beat          = bus.out_valid & bus.out_ready;
    assign mux_out       = select_q ? bus.data_b : bus.data_a;
    assign bus.out_data  = mux_out;

    // State register, mux select, round-robin history and burst counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            select_q   <= 1'b0;
            last_b_q   <= 1'b1;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            select_q   <= select_d;
            last_b_q   <= last_b_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Next-state arbitration: tie-break on history, release on req drop, hand over at burst end
    always_comb begin
        logic   own_req;
        logic   other_req;
        state_t other_state;

        state_d     = state_q;
        select_d    = select_q;
        last_b_d    = last_b_q;
        beat_cnt_d  = beat_cnt_q;
        own_req     = 1'b0;
        other_req   = 1'b0;
        other_state = IDLE;

        case (state_q)
            IDLE: begin
                beat_cnt_d = '0;
                if (bus.req_a && bus.req_b) begin
                    state_d = last_b_q ? OWN_A : OWN_B;
                end else if (bus.req_a) begin
                    state_d = OWN_A;
                end else if (bus.req_b) begin
                    state_d = OWN_B;
                end
            end
            OWN_A, OWN_B: begin
                own_req     = (state_q == OWN_A) ? bus.req_a : bus.req_b;
                other_req   = (state_q == OWN_A) ? bus.req_b : bus.req_a;
                other_state = (state_q == OWN_A) ? OWN_B : OWN_A;
                if (!own_req) begin
                    state_d    = other_req ? other_state : IDLE;
                    last_b_d   = (state_q == OWN_B);
                    beat_cnt_d = '0;
                end else if (beat) begin
                    if (beat_cnt_q == CNT_LAST) begin
                        beat_cnt_d = '0;
                        if (other_req) begin
                            state_d  = other_state;
                            last_b_d = (state_q == OWN_B);
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                beat_cnt_d = '0;
            end
        endcase

        case (state_d)
            OWN_A:   select_d = 1'b0;
            OWN_B:   select_d = 1'b1;
            default: select_d = select_q;
        endcase
    end

`ifdef MUX_ARB_STATS_EN
    // Saturating count of accepted beats per requester
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_a <= 8'h00;
            cnt_b <= 8'h00;
        end else begin
            if (beat && bus.gnt_a && (cnt_a != 8'hFF)) begin
                cnt_a <= cnt_a + 8'd1;
            end
            if (beat && bus.gnt_b && (cnt_b != 8'hFF)) begin
                cnt_b <= cnt_b + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench for mux_arbiter (WIDTH=8, BURST_LEN=4).
// Directed per-cycle vectors push hand-computed expected beats into a queue; a monitor
// pops and compares whenever the DUT completes a beat. Status checks cover grants,
// select and out_valid in reset, idle, stall and hand-over cycles.
module tb_mux_arbiter;

    typedef struct {
        int         cyc;
        logic       sel;
        logic [7:0] data;
    } beat_t;

    logic  clk;
    logic  reset;
    int    cyc;
    int    checks;
    int    errors;
    beat_t exp_q[$];
    beat_t mon_e;

    mux_arbiter_if #(.WIDTH(8)) bus ();

`ifdef MUX_ARB_STATS_EN
    logic [7:0] cnt_a;
    logic [7:0] cnt_b;
`endif

    mux_arbiter #(
        .WIDTH     (8),
        .BURST_LEN (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef MUX_ARB_STATS_EN
        ,
        .cnt_a (cnt_a),
        .cnt_b (cnt_b)
`endif
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point; every check in the bench goes through here
    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: cycle %0d got %h, required %h", name, cyc, got, exp);
        end
    endtask

    // One cycle of stimulus driven just after the rising edge; queue the expected beat if any
    task automatic applyStimulus(input logic rst, input logic ra, input logic [7:0] da,
                                 input logic rb, input logic [7:0] db, input logic rdy,
                                 input logic exp_beat, input logic exp_sel);
        beat_t e;
        @(posedge clk);
        #1;
        reset         = rst;
        bus.req_a     = ra;
        bus.data_a    = da;
        bus.req_b     = rb;
        bus.data_b    = db;
        bus.out_ready = rdy;
        cyc++;
        if (exp_beat) begin
            e.cyc  = cyc;
            e.sel  = exp_sel;
            e.data = exp_sel ? db : da;
            exp_q.push_back(e);
        end
    endtask

    // Mid-cycle check of grants, select and out_valid
    task automatic checkStatus(input string name, input logic ga, input logic gb,
                               input logic sel, input logic vld);
        @(negedge clk);
        checkOutput(name, {28'd0, bus.gnt_a, bus.gnt_b, bus.select, bus.out_valid},
                    {28'd0, ga, gb, sel, vld});
    endtask

`ifdef MUX_ARB_STATS_EN
    task automatic checkStats(input string name, input logic [7:0] ea, input logic [7:0] eb);
        @(negedge clk);
        checkOutput(name, {16'd0, cnt_a, cnt_b}, {16'd0, ea, eb});
    endtask
`endif

    // Monitor: every accepted beat must match the next queued expectation
    always @(negedge clk) begin
        if (reset === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_beat: cycle %0d got data %h select %b, required no beat",
                         cyc, bus.out_data, bus.select);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("beat", {5'd0, cyc[15:0], bus.gnt_a, bus.gnt_b, bus.select, bus.out_data},
                            {5'd0, mon_e.cyc[15:0], ~mon_e.sel, mon_e.sel, mon_e.sel, mon_e.data});
            end
        end
    end

    // Directed sequence
    initial begin
        cyc           = 0;
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        bus.req_a     = 1'b1;
        bus.data_a    = 8'h00;
        bus.req_b     = 1'b1;
        bus.data_b    = 8'h00;
        bus.out_ready = 1'b0;

        // Reset held with both requesting: no grant, then A wins the first tie
        applyStimulus(1, 1, 8'h00, 1, 8'h00, 0, 0, 0);
        checkStatus("reset_c1", 0, 0, 0, 0);
        applyStimulus(0, 1, 8'h00, 1, 8'h00, 0, 0, 0);
        checkStatus("reset_c2", 0, 0, 0, 0);

        // A alone for 6 beats: burst counter wraps without releasing
        applyStimulus(0, 1, 8'hA5, 0, 8'h00, 1, 1, 0);
        checkStatus("first_grant_a", 1, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 8'hA5, 0, 8'h00, 1, 1, 0);
        end
        checkStatus("burst_wrap_hold", 1, 0, 0, 1);

        // A drops with B idle -> IDLE; then a tie goes to B since A was last
        applyStimulus(0, 0, 8'hA5, 0, 8'h00, 1, 0, 0);
        checkStatus("release_valid_low", 1, 0, 0, 0);
        applyStimulus(0, 1, 8'h11, 1, 8'h22, 1, 0, 0);
        checkStatus("idle_after_release", 0, 0, 0, 0);

        // Both requesting: B x4, A x4, B x4 with no bubble
        applyStimulus(0, 1, 8'h11, 1, 8'h22, 1, 1, 1);
        checkStatus("tie_goes_to_b", 0, 1, 1, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 8'h11, 1, 8'h22, 1, 1, 1);
        end
        applyStimulus(0, 1, 8'h11, 1, 8'h22, 1, 1, 0);
        checkStatus("switch_to_a_no_bubble", 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 8'h11, 1, 8'h22, 1, 1, 0);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 8'h11, 1, 8'h22, 1, 1, 1);
        end

        // A burst with a 3-cycle stall after its 2nd beat: switch only after the 4th accepted beat
        applyStimulus(0, 1, 8'h11, 1, 8'h22, 1, 1, 0);
        applyStimulus(0, 1, 8'h11, 1, 8'h22, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 8'h11, 1, 8'h22, 0, 0, 0);
            checkStatus("stall_hold", 1, 0, 0, 1);
        end
        applyStimulus(0, 1, 8'h11, 1, 8'h22, 1, 1, 0);
        applyStimulus(0, 1, 8'h11, 1, 8'h22, 1, 1, 0);
        checkStatus("fourth_beat_still_a", 1, 0, 0, 1);
        applyStimulus(0, 1, 8'h11, 1, 8'h22, 1, 1, 1);
        checkStatus("switch_after_stall", 0, 1, 1, 1);

        // B drops with A idle -> IDLE, select keeps its last value
        applyStimulus(0, 0, 8'h11, 0, 8'h22, 1, 0, 0);
        checkStatus("b_release_valid_low", 0, 1, 1, 0);
        applyStimulus(0, 0, 8'h11, 0, 8'h22, 1, 0, 0);
        checkStatus("idle_select_held", 0, 0, 1, 0);

`ifdef MUX_ARB_STATS_EN
        // Beat counters: 14 A beats and 9 B beats so far, cleared by reset, A saturates
        applyStimulus(1, 0, 8'h5A, 0, 8'h00, 0, 0, 0);
        checkStats("stats_before_reset", 8'd14, 8'd9);
        applyStimulus(0, 1, 8'h5A, 0, 8'h00, 1, 0, 0);
        checkStats("stats_cleared", 8'h00, 8'h00);
        for (int i = 0; i < 300; i++) begin
            applyStimulus(0, 1, 8'h5A, 0, 8'h00, 1, 1, 0);
        end
        applyStimulus(1, 0, 8'h5A, 0, 8'h00, 0, 0, 0);
        checkStats("stats_saturated", 8'hFF, 8'h00);
        applyStimulus(0, 0, 8'h5A, 0, 8'h00, 0, 0, 0);
        checkStats("stats_reset_pulse", 8'h00, 8'h00);
`endif

        @(negedge clk);
        checkOutput("pending_beats", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
